// File: rtl/argmax_pkg.sv
`default_nettype none
// ============================================================================
// Module   : argmax_pkg
// Purpose  : Shared definitions for the streaming argmax block: the clog2
//            helper used to size the index and scan pointer, the state
//            encoding and the compare-mode selectors.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package argmax_pkg;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Index width never drops below one bit, even for a single-element vector.
  function automatic int idx_width(input int num_input);
    return (clog2(num_input) < 1) ? 1 : clog2(num_input);
  endfunction

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_SCAN = ST_SCAN,
    S_DONE = ST_DONE
  } state_e;

  localparam int CMP_UNSIGNED = 0;
  localparam int CMP_SIGNED   = 1;

endpackage : argmax_pkg
`default_nettype wire

// File: rtl/argmax_lane_reduce.sv
`default_nettype none
// ============================================================================
// Module   : argmax_lane_reduce
// Purpose  : Combinational reduction of LANES candidates against the running
//            maximum. A candidate replaces the current best only when it is
//            strictly greater, so ties keep the earlier (lower) index.
// Ports    : i_cand_value/i_cand_index/i_cand_valid - per-lane candidates
//            i_max_value/i_max_index                - incoming running max
//            o_max_value/o_max_index                - winner after this step
// Revision : 1.0 - initial release
// ============================================================================
module argmax_lane_reduce
  import argmax_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int INPUT_WIDTH = 16,
  parameter int IDX_WIDTH   = 4,
  parameter int SIGNED      = 1
) (
  input  logic [LANES-1:0][INPUT_WIDTH-1:0] i_cand_value,
  input  logic [LANES-1:0][IDX_WIDTH-1:0]   i_cand_index,
  input  logic [LANES-1:0]                  i_cand_valid,
  input  logic [INPUT_WIDTH-1:0]            i_max_value,
  input  logic [IDX_WIDTH-1:0]              i_max_index,
  output logic [INPUT_WIDTH-1:0]            o_max_value,
  output logic [IDX_WIDTH-1:0]              o_max_index
);

  function automatic logic is_greater(input logic [INPUT_WIDTH-1:0] a,
                                      input logic [INPUT_WIDTH-1:0] b);
    if (SIGNED == CMP_SIGNED) begin
      return $signed(a) > $signed(b);
    end
    return a > b;
  endfunction

  logic [INPUT_WIDTH-1:0] best_value;
  logic [IDX_WIDTH-1:0]   best_index;

  // Lanes carry ascending indices, all above the running max index, so a
  // sequential strictly-greater chain yields first-occurrence semantics.
  always_comb begin
    best_value = i_max_value;
    best_index = i_max_index;
    for (int k = 0; k < LANES; k++) begin
      if (i_cand_valid[k] && is_greater(i_cand_value[k], best_value)) begin
        best_value = i_cand_value[k];
        best_index = i_cand_index[k];
      end
    end
  end

  assign o_max_value = best_value;
  assign o_max_index = best_index;

endmodule : argmax_lane_reduce
`default_nettype wire

// File: rtl/argmax_stream.sv
`default_nettype none
// ============================================================================
// Module   : argmax_stream
// Purpose  : Streaming argmax. Latches a packed vector of NUM_INPUT scores,
//            scans LANES elements per cycle and presents the index and value
//            of the largest element with a ready/valid result handshake.
// Ports    : i_clk, i_rst (async, active-high)
//            i_data/i_valid/o_ready   - input vector handshake
//            o_index/o_value/o_valid  - result, held until i_ready
//            i_ready                  - downstream accepts result
// Revision : 1.0 - initial release
// ============================================================================
module argmax_stream
  import argmax_pkg::*;
#(
  parameter int NUM_INPUT   = 10,
  parameter int INPUT_WIDTH = 16,
  parameter int LANES       = 2,
  parameter int SIGNED      = 1,
  parameter int IDX_WIDTH   = idx_width(NUM_INPUT)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_INPUT*INPUT_WIDTH-1:0] i_data,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic [IDX_WIDTH-1:0]             o_index,
  output logic [INPUT_WIDTH-1:0]           o_value,
  output logic                             o_valid,
  input  logic                             i_ready
);

  localparam int W = INPUT_WIDTH;
  // Pointer must hold ptr+LANES without wrapping for the end-of-scan test.
  localparam int PTR_WIDTH = clog2(NUM_INPUT + LANES + 1);

  state_e                   state_q, state_d;
  logic [NUM_INPUT*W-1:0]   data_q, data_d;
  logic [PTR_WIDTH-1:0]     ptr_q, ptr_d;
  logic [W-1:0]             run_value_q, run_value_d;
  logic [IDX_WIDTH-1:0]     run_index_q, run_index_d;
  logic [W-1:0]             value_q, value_d;
  logic [IDX_WIDTH-1:0]     index_q, index_d;

  logic [LANES-1:0][PTR_WIDTH-1:0] lane_pos;
  logic [LANES-1:0][W-1:0]         cand_value;
  logic [LANES-1:0][IDX_WIDTH-1:0] cand_index;
  logic [LANES-1:0]                cand_valid;
  logic [W-1:0]                    red_value;
  logic [IDX_WIDTH-1:0]            red_index;
  logic                            scan_last;

  // Lane k looks at element ptr+k; positions past the vector end are masked.
  always_comb begin
    lane_pos   = '0;
    cand_value = '0;
    cand_index = '0;
    cand_valid = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_pos[k]   = ptr_q + PTR_WIDTH'(k);
      cand_valid[k] = (lane_pos[k] < PTR_WIDTH'(NUM_INPUT));
      cand_index[k] = IDX_WIDTH'(lane_pos[k]);
      for (int j = 0; j < NUM_INPUT; j++) begin
        if (lane_pos[k] == PTR_WIDTH'(j)) begin
          cand_value[k] = data_q[j*W +: W];
        end
      end
    end
  end

  argmax_lane_reduce #(
    .LANES       (LANES),
    .INPUT_WIDTH (W),
    .IDX_WIDTH   (IDX_WIDTH),
    .SIGNED      (SIGNED)
  ) u_reduce (
    .i_cand_value (cand_value),
    .i_cand_index (cand_index),
    .i_cand_valid (cand_valid),
    .i_max_value  (run_value_q),
    .i_max_index  (run_index_q),
    .o_max_value  (red_value),
    .o_max_index  (red_index)
  );

  assign scan_last = ((ptr_q + PTR_WIDTH'(LANES)) >= PTR_WIDTH'(NUM_INPUT));

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    ptr_d       = ptr_q;
    run_value_d = run_value_q;
    run_index_d = run_index_q;
    value_d     = value_q;
    index_d     = index_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          data_d      = i_data;
          run_value_d = i_data[W-1:0];
          run_index_d = '0;
          ptr_d       = PTR_WIDTH'(1);
          if (NUM_INPUT == 1) begin
            // Nothing to scan: element 0 is the answer immediately.
            value_d = i_data[W-1:0];
            index_d = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        run_value_d = red_value;
        run_index_d = red_index;
        ptr_d       = ptr_q + PTR_WIDTH'(LANES);
        if (scan_last) begin
          value_d = red_value;
          index_d = red_index;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      ptr_q       <= '0;
      run_value_q <= '0;
      run_index_q <= '0;
      value_q     <= '0;
      index_q     <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      ptr_q       <= ptr_d;
      run_value_q <= run_value_d;
      run_index_q <= run_index_d;
      value_q     <= value_d;
      index_q     <= index_d;
    end
  end

  // All outputs decode registered state only.
  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign o_index = index_q;
  assign o_value = value_q;

endmodule : argmax_stream
`default_nettype wire
